// File: rtl/rvfi_seq_pkg.sv
// rtl/rvfi_seq_pkg.sv - shared types and helpers for the RVFI trigger sequencer
package rvfi_seq_pkg;

    localparam int ORDER_W = 64;
    localparam int MAX_RET = 32;
    localparam int POP_W   = 6;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_TMO   = 3'd5
    } seq_state_e;

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_RET-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_RET; i++) begin
            n = n + {{(POP_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rvfi_sat_counter.sv
// rtl/rvfi_sat_counter.sv - saturating up-counter with variable increment
module rvfi_sat_counter #(
    parameter int CNT_W = 16,
    parameter int INC_W = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count
);

    // One extra bit of headroom so the carry out of the add is never lost.
    localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam logic [SUM_W-1:0] MAX_VAL = SUM_W'({CNT_W{1'b1}});

    logic [SUM_W-1:0] sum;

    assign sum = SUM_W'(count) + SUM_W'(inc);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            count <= (sum > MAX_VAL) ? '1 : CNT_W'(sum);
        end
    end

endmodule

// File: rtl/rvfi_trig_seq.sv
// rtl/rvfi_trig_seq.sv - picks one RVFI retirement as the checked instruction and sequences check
module rvfi_trig_seq
    import rvfi_seq_pkg::*;
#(
    parameter int NRET        = 1,
    parameter int CHANNEL_IDX = 0,
    parameter int TRIG_CYCLE  = 10,
    parameter int CHECK_DELAY = 5,
    parameter int TIMEOUT     = 32,
    parameter int CNT_W       = 16
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [ORDER_W*NRET-1:0] rvfi_order,
    output logic                    trig,
    output logic                    check,
    output logic [ORDER_W-1:0]      trig_order,
    output logic [CNT_W-1:0]        retire_cnt,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic                    timeout,
    output logic [2:0]              state
);

    seq_state_e         state_q, state_d;
    logic [31:0]        dly_q, dly_d;
    logic [31:0]        arm_q, arm_d;
    logic [ORDER_W-1:0] order_d;
    logic               tmo_d, check_d;
    logic               arm_now, chan_valid;
    logic [MAX_RET-1:0] valid_ext;
    logic [POP_W-1:0]   retire_inc;

    assign valid_ext  = MAX_RET'(rvfi_valid);
    assign retire_inc = popcount(valid_ext);
    assign chan_valid = rvfi_valid[CHANNEL_IDX];
    assign arm_now    = (cycle_cnt == CNT_W'((TRIG_CYCLE > 0) ? TRIG_CYCLE - 1 : 0));

    // The checker samples rvfi_* and trig together, so trig must be combinational.
    assign trig  = resetn && (state_q == ST_ARMED) && chan_valid;
    assign state = state_q;

    rvfi_sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_cycle_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (1'b1),
        .count  (cycle_cnt)
    );

    rvfi_sat_counter #(.CNT_W(CNT_W), .INC_W(POP_W)) u_retire_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (retire_inc),
        .count  (retire_cnt)
    );

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        arm_d   = arm_q;
        order_d = trig_order;
        tmo_d   = timeout;
        check_d = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (arm_now) begin
                    state_d = ST_ARMED;
                    arm_d   = '0;
                end
            end
            ST_ARMED: begin
                // A candidate in the same cycle as the timeout limit still wins.
                if (chan_valid) begin
                    order_d = rvfi_order[ORDER_W*CHANNEL_IDX +: ORDER_W];
                    if (CHECK_DELAY <= 1) begin
                        state_d = ST_CHECK;
                        check_d = 1'b1;
                    end else begin
                        state_d = ST_DELAY;
                        dly_d   = 32'(CHECK_DELAY - 1);
                    end
                end else if (arm_q == 32'(TIMEOUT - 1)) begin
                    state_d = ST_TMO;
                    tmo_d   = 1'b1;
                end else begin
                    arm_d = arm_q + 32'd1;
                end
            end
            ST_DELAY: begin
                if (dly_q <= 32'd1) begin
                    state_d = ST_CHECK;
                    check_d = 1'b1;
                end else begin
                    dly_d = dly_q - 32'd1;
                end
            end
            ST_CHECK: state_d = ST_DONE;
            ST_TMO:   state_d = ST_TMO;
            default:  state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_WAIT;
            dly_q      <= '0;
            arm_q      <= '0;
            trig_order <= '0;
            timeout    <= 1'b0;
            check      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            arm_q      <= arm_d;
            trig_order <= order_d;
            timeout    <= tmo_d;
            check      <= check_d;
        end
    end

endmodule

// File: tb/tb_rvfi_trig_seq.sv
// tb/tb_rvfi_trig_seq.sv - scoreboard bench for rvfi_trig_seq
module tb_rvfi_trig_seq;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          unit;
        bit          is_check;
        int          cyc;
        logic [63:0] order;
    } ev_t;

    ev_t exp_q[$];

    // unit 0: default parameters
    logic        a_resetn, a_valid, a_trig, a_check, a_timeout;
    logic [63:0] a_order, a_trig_order;
    logic [15:0] a_retire, a_cycle;
    logic [2:0]  a_state;

    // unit 1: two channels, trig on channel 1, CHECK_DELAY=1
    logic         b_resetn, b_trig, b_check, b_timeout;
    logic [1:0]   b_valid;
    logic [127:0] b_order;
    logic [63:0]  b_trig_order;
    logic [15:0]  b_retire, b_cycle;
    logic [2:0]   b_state;

    // unit 2: two channels, 4-bit counters
    logic         c_resetn, c_trig, c_check, c_timeout;
    logic [1:0]   c_valid;
    logic [127:0] c_order;
    logic [63:0]  c_trig_order;
    logic [3:0]   c_retire, c_cycle;
    logic [2:0]   c_state;

    rvfi_trig_seq dut_a (
        .clock(clock), .resetn(a_resetn), .rvfi_valid(a_valid), .rvfi_order(a_order),
        .trig(a_trig), .check(a_check), .trig_order(a_trig_order), .retire_cnt(a_retire),
        .cycle_cnt(a_cycle), .timeout(a_timeout), .state(a_state)
    );

    rvfi_trig_seq #(.NRET(2), .CHANNEL_IDX(1), .CHECK_DELAY(1)) dut_b (
        .clock(clock), .resetn(b_resetn), .rvfi_valid(b_valid), .rvfi_order(b_order),
        .trig(b_trig), .check(b_check), .trig_order(b_trig_order), .retire_cnt(b_retire),
        .cycle_cnt(b_cycle), .timeout(b_timeout), .state(b_state)
    );

    rvfi_trig_seq #(.NRET(2), .CNT_W(4)) dut_c (
        .clock(clock), .resetn(c_resetn), .rvfi_valid(c_valid), .rvfi_order(c_order),
        .trig(c_trig), .check(c_check), .trig_order(c_trig_order), .retire_cnt(c_retire),
        .cycle_cnt(c_cycle), .timeout(c_timeout), .state(c_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int unit, input bit is_check, input int at, input logic [63:0] order);
        exp_q.push_back('{unit: unit, is_check: is_check, cyc: at, order: order});
    endtask

    task automatic obs(input int unit, input logic t, input logic c, input logic [63:0] held);
        ev_t ev;
        if (t || c) begin
            if (exp_q.size() == 0) begin
                chk($sformatf("unexpected_event_u%0d_c%0d", unit, cyc), {62'd0, t, c}, 64'd0);
            end else begin
                ev = exp_q.pop_front();
                chk($sformatf("event_kind_u%0d_c%0d", unit, cyc),
                    64'(unit * 2) + {63'd0, c}, 64'(ev.unit * 2 + (ev.is_check ? 1 : 0)));
                chk($sformatf("event_cycle_u%0d", unit), 64'(cyc), 64'(ev.cyc));
                if (c) chk($sformatf("check_trig_order_u%0d", unit), held, ev.order);
            end
        end
    endtask

    always @(negedge clock) begin
        obs(0, a_trig, a_check, a_trig_order);
        obs(1, b_trig, b_check, b_trig_order);
        obs(2, c_trig, c_check, c_trig_order);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic restart_a();
        a_resetn = 1'b0;
        a_valid  = 1'b0;
        tick();
        a_resetn = 1'b1;
    endtask

    initial begin
        a_resetn = 1'b0; b_resetn = 1'b0; c_resetn = 1'b0;
        a_valid  = 1'b1; a_order  = 64'd77;
        b_valid  = 2'b00; b_order = '0;
        c_valid  = 2'b00; c_order = '0;

        // Reset state with a valid retirement presented: trig must stay low.
        repeat (3) tick();
        @(negedge clock);
        chk("rst_trig", {63'd0, a_trig}, 64'd0);
        chk("rst_check", {63'd0, a_check}, 64'd0);
        chk("rst_state", {61'd0, a_state}, 64'd0);
        chk("rst_cycle", {48'd0, a_cycle}, 64'd0);
        chk("rst_retire", {48'd0, a_retire}, 64'd0);
        chk("rst_trig_order", a_trig_order, 64'd0);
        chk("rst_timeout", {63'd0, a_timeout}, 64'd0);

        // Valid every cycle, order = cycle number.
        push(0, 0, 10, 64'd0);
        push(0, 1, 15, 64'd10);
        tick();
        a_resetn = 1'b1;
        for (int c = 0; c <= 21; c++) begin
            cyc = c; a_valid = 1'b1; a_order = 64'(c);
            @(negedge clock);
            if (c == 9)  chk("s1_state_c9", {61'd0, a_state}, 64'd0);
            if (c == 10) chk("s1_state_c10", {61'd0, a_state}, 64'd1);
            if (c == 11) chk("s1_state_c11", {61'd0, a_state}, 64'd2);
            if (c == 15) chk("s1_state_c15", {61'd0, a_state}, 64'd3);
            if (c == 16) chk("s1_state_c16", {61'd0, a_state}, 64'd4);
            if (c == 20) begin
                chk("s1_retire_c20", {48'd0, a_retire}, 64'd20);
                chk("s1_cycle_c20", {48'd0, a_cycle}, 64'd20);
                chk("s1_trig_order", a_trig_order, 64'd10);
            end
            tick();
        end

        // No retirements: timeout after 32 armed cycles.
        restart_a();
        for (int c = 0; c <= 45; c++) begin
            cyc = c; a_valid = 1'b0; a_order = 64'(c);
            @(negedge clock);
            if (c == 10) chk("s2_armed_c10", {61'd0, a_state}, 64'd1);
            if (c == 41) begin
                chk("s2_state_c41", {61'd0, a_state}, 64'd1);
                chk("s2_tmo_c41", {63'd0, a_timeout}, 64'd0);
            end
            if (c == 42) begin
                chk("s2_state_c42", {61'd0, a_state}, 64'd5);
                chk("s2_tmo_c42", {63'd0, a_timeout}, 64'd1);
            end
            if (c == 45) chk("s2_tmo_sticky", {63'd0, a_timeout}, 64'd1);
            tick();
        end

        // Candidate on the last armed cycle beats the timeout.
        restart_a();
        push(0, 0, 41, 64'd0);
        push(0, 1, 46, 64'hABCD);
        for (int c = 0; c <= 47; c++) begin
            cyc = c; a_valid = (c == 41); a_order = (c == 41) ? 64'hABCD : 64'(c);
            @(negedge clock);
            if (c == 42) begin
                chk("s4_state_c42", {61'd0, a_state}, 64'd2);
                chk("s4_tmo_c42", {63'd0, a_timeout}, 64'd0);
            end
            if (c == 47) chk("s4_state_c47", {61'd0, a_state}, 64'd4);
            tick();
        end

        // Reset pulse while in DELAY, then a full rerun.
        restart_a();
        push(0, 0, 10, 64'd0);
        for (int c = 0; c <= 13; c++) begin
            cyc = c; a_valid = 1'b1; a_order = 64'(100 + c);
            @(negedge clock);
            if (c == 13) chk("s3_delay_c13", {61'd0, a_state}, 64'd2);
            if (c != 13) tick();
        end
        a_resetn = 1'b0;
        #1;
        chk("s3_rst_trig", {63'd0, a_trig}, 64'd0);
        chk("s3_rst_check", {63'd0, a_check}, 64'd0);
        chk("s3_rst_state", {61'd0, a_state}, 64'd0);
        chk("s3_rst_cycle", {48'd0, a_cycle}, 64'd0);
        chk("s3_rst_retire", {48'd0, a_retire}, 64'd0);
        chk("s3_rst_trig_order", a_trig_order, 64'd0);
        tick();
        a_resetn = 1'b1;
        push(0, 0, 10, 64'd0);
        push(0, 1, 15, 64'd110);
        for (int c = 0; c <= 16; c++) begin
            cyc = c; a_valid = 1'b1; a_order = 64'(100 + c);
            @(negedge clock);
            if (c == 0) chk("s3_cycle_c0", {48'd0, a_cycle}, 64'd0);
            if (c == 5) chk("s3_cycle_c5", {48'd0, a_cycle}, 64'd5);
            tick();
        end
        a_resetn = 1'b0;
        a_valid  = 1'b0;

        // Channel 1 is the trig channel; channel 0 retires from cycle 0.
        push(1, 0, 14, 64'd0);
        push(1, 1, 15, 64'h100E);
        b_resetn = 1'b1;
        for (int c = 0; c <= 17; c++) begin
            cyc = c;
            b_valid = {(c >= 14), 1'b1};
            b_order = {64'h1000 + 64'(c), 64'(c)};
            @(negedge clock);
            if (c == 13) chk("b_retire_c13", {48'd0, b_retire}, 64'd13);
            if (c == 14) chk("b_retire_c14", {48'd0, b_retire}, 64'd14);
            if (c == 15) begin
                chk("b_retire_c15", {48'd0, b_retire}, 64'd16);
                chk("b_state_c15", {61'd0, b_state}, 64'd3);
            end
            if (c == 16) chk("b_state_c16", {61'd0, b_state}, 64'd4);
            if (c == 17) chk("b_retire_c17", {48'd0, b_retire}, 64'd20);
            tick();
        end
        b_resetn = 1'b0;
        b_valid  = 2'b00;

        // 4-bit counters, both channels retiring every cycle.
        push(2, 0, 10, 64'd0);
        push(2, 1, 15, 64'd10);
        c_resetn = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            cyc = c;
            c_valid = 2'b11;
            c_order = {64'(500 + c), 64'(c)};
            @(negedge clock);
            if (c == 7)  chk("c_retire_c7", {60'd0, c_retire}, 64'd14);
            if (c == 8)  chk("c_retire_sat_c8", {60'd0, c_retire}, 64'd15);
            if (c == 14) chk("c_cycle_c14", {60'd0, c_cycle}, 64'd14);
            if (c == 20) begin
                chk("c_retire_sat_c20", {60'd0, c_retire}, 64'd15);
                chk("c_cycle_sat_c20", {60'd0, c_cycle}, 64'd15);
            end
            tick();
        end
        c_resetn = 1'b0;

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
